// File: rtl/serial_addsub_ctrl.sv
// Bit-serial W-bit adder/subtractor: one full-adder cell plus carry flop, sequenced by an IDLE/RUN/DONE FSM.
// Define SERIAL_ADDSUB_OVF_EN to build the MSB carry-in capture and the two's-complement overflow output.
module serial_addsub_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_q;
   logic [W-1:0] opa_q, opb_q, acc_q, result_q;
   logic [CW-1:0] cnt_q;
   logic         carry_q, busy_q, done_q, cout_q;
   logic         sum_d, carry_d, accept_d, last_d;

   function automatic logic majority(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   always_comb begin
      sum_d    = opa_q[0] ^ opb_q[0] ^ carry_q;
      carry_d  = majority(opa_q[0], opb_q[0], carry_q);
      last_d   = (cnt_q == CW'(W - 1));
      accept_d = start && (state_q == IDLE || state_q == DONE);
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic cmsb_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmsb_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (state_q == RUN && last_d)
            cmsb_q <= carry_q;
         if (state_q == DONE)
            ovf_q <= cmsb_q ^ carry_q;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         // busy and done are registered views of the state, one cycle behind it
         busy_q <= (state_q == RUN);
         done_q <= (state_q == DONE);
         case (state_q)
            RUN: begin
               carry_q <= carry_d;
               opa_q   <= opa_q >> 1;
               opb_q   <= opb_q >> 1;
               acc_q   <= {sum_d, acc_q[W-1:1]};
               cnt_q   <= cnt_q + CW'(1);
               if (last_d)
                  state_q <= DONE;
            end
            DONE: begin
               result_q <= acc_q;
               cout_q   <= carry_q;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // Subtraction is a + ~b + 1: invert b and preload the carry with sub
         if (accept_d) begin
            opa_q   <= a;
            opb_q   <= b ^ {W{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial adder/subtractor controller: accepts two W-bit operands on a start pulse and produces their sum or difference one bit per clock through a single 1-bit full-adder cell and a carry flip-flop. The control FSM sequences the shared adder cell, runs a start/busy/done handshake, and registers the final result. The block provides the multi-bit arithmetic path in area-constrained parts of the adders/subtractors library, where a W-bit ripple adder is not wanted.

## Interface
- W, default 8: operand and result width; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled on the rising edge of clk.
- sub  input  1  operation select, sampled with start: 0 = a+b, 1 = a-b.
- a  input  W  first operand (minuend), sampled with start.
- b  input  W  second operand (subtrahend), sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle.
- result  output  W  registered sum or difference; holds its value until the next done.
- cout  output  1  final carry out. For subtraction, 1 means no borrow.
- ovf  output  1  two's-complement overflow flag (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch opA=a and opB=b^{W{sub}}, carry=sub, bit counter=0, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - s = opA[0]^opB[0]^carry.
  - carry <= majority(opA[0], opB[0], carry).
  - Shift opA and opB right by one.
  - Shift s into the MSB of the internal accumulator.
  - Increment the counter.
- The carry into the MSB is captured when the counter equals W-1.
- When the counter reaches W-1 the cycle processes the last bit, then the FSM goes to DONE.
- DONE: load result from the accumulator and cout from carry; pulse done.
  - DONE with start=1: accept the new operation immediately, as in IDLE.
  - DONE with start=0: go to IDLE.
- start while in RUN is ignored. Operands are not re-sampled.
- Arithmetic is modulo 2^W.
- ovf = (carry into MSB) XOR (carry out of MSB).

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter and internal registers = 0.
- start is sampled at edge E0.
  - busy is high for cycles E0+1 through E0+W, which is exactly W cycles.
  - done is high for the single cycle after edge E0+W+1.
  - result, cout and ovf update at that same edge.
- Latency from start edge to done: W+1 cycles.
- Back-to-back throughput: one operation every W+1 cycles.
- result, cout and ovf do not change during RUN. They always show the last completed operation.
- Asserting rst_n low in any state returns the block to its reset values immediately. The operation in progress is discarded and done is not issued for it.
- a, b and sub have no effect outside the start-sampling cycle.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - The MSB carry-in capture register and the ovf output logic are built.
  - ovf updates together with done.
- SERIAL_ADDSUB_OVF_EN undefined:
  - The capture register is not built.
  - ovf is tied to 0.
  - All other behaviour is identical.

## Test plan
- W=8, a=0x3C, b=0x05, sub=0: busy high for 8 cycles, then done for 1 cycle; result=0x41, cout=0, ovf=0.
- W=8, a=0xFF, b=0x01, sub=0: result=0x00, cout=1, ovf=0.
- With SERIAL_ADDSUB_OVF_EN, W=8, a=0x7F, b=0x01, sub=0: result=0x80, ovf=1. Without the macro: ovf=0, result=0x80.
- W=8, a=0x05, b=0x07, sub=1: result=0xFE, cout=0 (borrow).
  - Same run with a=0x07, b=0x05: result=0x02, cout=1.
- W=8, start with a=0x10, b=0x20, then start pulsed mid-RUN with other operands: those later operands are ignored; result=0x30 at E0+9.
  - Start held high through DONE: the second operation starts with no idle cycle.
- W=8, rst_n pulsed low at cycle E0+4: all outputs read 0, no done pulse follows, and the next start completes correctly.
